// File: rtl/fb_pkg.sv
// Shared frame-buffer write-port definitions: geometry defaults, field widths,
// the pixel record and the scheduler state encoding.
package fb_pkg;

  localparam int unsigned FB_WIDTH_DEF  = 160;
  localparam int unsigned FB_HEIGHT_DEF = 120;
  localparam int unsigned COORD_W       = 8;
  localparam int unsigned COLOR_W       = 3;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } fb_pixel_t;

  localparam logic [0:0] ARB   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

endpackage

// File: rtl/fb_clear_sweeper.sv
// Raster counters for the full-frame clear: x runs fastest, both wrap to 0
// after the last pixel so the next sweep starts clean.
module fb_clear_sweeper
  import fb_pkg::*;
#(
  parameter int unsigned Width  = FB_WIDTH_DEF,
  parameter int unsigned Height = FB_HEIGHT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               advance_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               x_end, y_end;

  assign x_end  = (32'(x_q) == Width - 1);
  assign y_end  = (32'(y_q) == Height - 1);
  assign last_o = x_end && y_end;
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Round-robin arbiter for two pixel producers onto the frame-buffer write port,
// with a pre-empting full-frame clear sweep and an out-of-range drop counter.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH    = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT   = FB_HEIGHT_DEF,
  parameter logic [8:0]  CLEAR_COLOR = 9'h000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_start,
  output logic         clear_busy,
  output logic         clear_done,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [7:0]   req0_x,
  input  logic [7:0]   req0_y,
  input  logic [2:0]   req0_r,
  input  logic [2:0]   req0_g,
  input  logic [2:0]   req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [7:0]   req1_x,
  input  logic [7:0]   req1_y,
  input  logic [2:0]   req1_r,
  input  logic [2:0]   req1_g,
  input  logic [2:0]   req1_b,
  output logic         out_we,
  output logic [7:0]   out_x,
  output logic [7:0]   out_y,
  output logic [2:0]   out_r,
  output logic [2:0]   out_g,
  output logic [2:0]   out_b,
  output logic [15:0]  oob_count
);

  logic [0:0]         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               out_we_q, out_we_d;
  fb_pixel_t          out_pix_q, out_pix_d;
  logic               done_q, done_d;
  logic [15:0]        oob_q, oob_d;

  logic               arb_ok, grant0, grant1, xfer, in_range, clear_go, sweeping;
  fb_pixel_t          pix0, pix1, sel_pix;
  logic [COORD_W-1:0] cx, cy;
  logic               c_last;

  assign pix0 = {req0_x, req0_y, req0_r, req0_g, req0_b};
  assign pix1 = {req1_x, req1_y, req1_r, req1_g, req1_b};

  // last_grant_q == 1 means req1 won the previous transfer, so req0 wins a tie.
  assign arb_ok   = (state_q == ARB) && !clear_start && !reset;
  assign grant0   = arb_ok && req0_valid && (!req1_valid || last_grant_q);
  assign grant1   = arb_ok && req1_valid && (!req0_valid || !last_grant_q);
  assign xfer     = grant0 || grant1;
  assign sel_pix  = grant0 ? pix0 : pix1;
  assign in_range = (32'(sel_pix.x) < FB_WIDTH) && (32'(sel_pix.y) < FB_HEIGHT);
  assign clear_go = (state_q == ARB) && clear_start;
  assign sweeping = (state_q == CLEAR);

  fb_clear_sweeper #(
    .Width  (FB_WIDTH),
    .Height (FB_HEIGHT)
  ) u_sweeper (
    .clk_i     (clock),
    .rst_i     (reset),
    .start_i   (clear_go),
    .advance_i (sweeping),
    .x_o       (cx),
    .y_o       (cy),
    .last_o    (c_last)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_we_d     = 1'b0;
    out_pix_d    = out_pix_q;
    done_d       = 1'b0;
    oob_d        = oob_q;
    if (sweeping) begin
      out_we_d  = 1'b1;
      out_pix_d = {cx, cy, CLEAR_COLOR};
      done_d    = c_last;
      if (c_last) state_d = ARB;
    end else if (clear_go) begin
      state_d = CLEAR;
    end else if (xfer) begin
      last_grant_d = grant1;
      if (in_range) begin
        out_we_d  = 1'b1;
        out_pix_d = sel_pix;
      end else if (oob_q != 16'hFFFF) begin
        oob_d = oob_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      out_we_q     <= 1'b0;
      out_pix_q    <= '0;
      done_q       <= 1'b0;
      oob_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_we_q     <= out_we_d;
      out_pix_q    <= out_pix_d;
      done_q       <= done_d;
      oob_q        <= oob_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign clear_busy = sweeping;
  assign clear_done = done_q;
  assign out_we     = out_we_q;
  assign out_x      = out_pix_q.x;
  assign out_y      = out_pix_q.y;
  assign out_r      = out_pix_q.r;
  assign out_g      = out_pix_q.g;
  assign out_b      = out_pix_q.b;
  assign oob_count  = oob_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler on a 16x24 frame: expected writes are
// queued when a step is driven and popped against the registered outputs.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  localparam int unsigned TW = 16;
  localparam int unsigned TH = 24;
  localparam int unsigned NPIX = TW * TH;
  localparam logic [8:0] CLR_COLOR = 9'h000;

  typedef struct packed {
    logic      we;
    logic      done;
    fb_pixel_t pix;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear_start = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  fb_pixel_t p0 = '0, p1 = '0;
  logic clear_busy, clear_done, req0_ready, req1_ready, out_we;
  logic [7:0] out_x, out_y;
  logic [2:0] out_r, out_g, out_b;
  logic [15:0] oob_count;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  fb_pixel_t m_pix = '0;
  logic [15:0] m_oob = '0;

  always #5 clock = ~clock;

  fb_write_scheduler #(
    .FB_WIDTH    (TW),
    .FB_HEIGHT   (TH),
    .CLEAR_COLOR (CLR_COLOR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .req0_valid  (v0),
    .req0_ready  (req0_ready),
    .req0_x      (p0.x),
    .req0_y      (p0.y),
    .req0_r      (p0.r),
    .req0_g      (p0.g),
    .req0_b      (p0.b),
    .req1_valid  (v1),
    .req1_ready  (req1_ready),
    .req1_x      (p1.x),
    .req1_y      (p1.y),
    .req1_r      (p1.r),
    .req1_g      (p1.g),
    .req1_b      (p1.b),
    .out_we      (out_we),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_r       (out_r),
    .out_g       (out_g),
    .out_b       (out_b),
    .oob_count   (oob_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic fits(input fb_pixel_t p);
    return (32'(p.x) < TW) && (32'(p.y) < TH);
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    fb_pixel_t o;
    o = {out_x, out_y, out_r, out_g, out_b};
    chk({tag, "/we"}, 32'(out_we), 32'(e.we));
    chk({tag, "/pix"}, 32'(o), 32'(e.pix));
    chk({tag, "/done"}, 32'(clear_done), 32'(e.done));
    chk({tag, "/oob"}, 32'(oob_count), 32'(m_oob));
  endtask

  // One cycle: readies/busy checked mid-cycle, the write they imply checked after the edge.
  task automatic tick(input string tag, input logic er0, input logic er1, input logic ebusy,
                      input logic clr, input int unsigned k);
    exp_t e;
    fb_pixel_t acc;
    @(negedge clock);
    chk({tag, "/ready0"}, 32'(req0_ready), 32'(er0));
    chk({tag, "/ready1"}, 32'(req1_ready), 32'(er1));
    chk({tag, "/busy"}, 32'(clear_busy), 32'(ebusy));
    e.we   = 1'b0;
    e.done = 1'b0;
    e.pix  = m_pix;
    if (clr) begin
      e.we   = 1'b1;
      e.done = (k == NPIX - 1);
      e.pix  = {8'(k % TW), 8'(k / TW), CLR_COLOR};
    end else if (er0 || er1) begin
      acc = er0 ? p0 : p1;
      if (fits(acc)) begin
        e.we  = 1'b1;
        e.pix = acc;
      end else if (m_oob != 16'hFFFF) begin
        m_oob = m_oob + 16'd1;
      end
    end
    sb.push_back(e);
    if (e.we) m_pix = e.pix;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_outputs(tag, e);
  endtask

  task automatic do_reset(input string tag);
    exp_t z;
    reset = 1'b1;
    clear_start = 1'b0;
    v0 = 1'b1;
    v1 = 1'b1;
    @(negedge clock);
    chk({tag, "/ready0"}, 32'(req0_ready), 32'd0);
    chk({tag, "/ready1"}, 32'(req1_ready), 32'd0);
    @(posedge clock);
    #1;
    m_pix = '0;
    m_oob = '0;
    sb.delete();
    z = '0;
    chk({tag, "/busy"}, 32'(clear_busy), 32'd0);
    check_outputs(tag, z);
    reset = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic run_sweep(input string tag, input int unsigned restart_at);
    for (int unsigned k = 0; k < NPIX; k++) begin
      clear_start = (k == restart_at);
      tick(tag, 1'b0, 1'b0, 1'b1, 1'b1, k);
    end
    clear_start = 1'b0;
  endtask

  initial begin
    do_reset("reset");

    p0 = {8'd10, 8'd20, 3'd7, 3'd0, 3'd3};
    v0 = 1'b1;
    tick("single", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    v0 = 1'b0;
    tick("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    do_reset("reset2");
    p0 = {8'd1, 8'd2, 3'd1, 3'd1, 3'd1};
    p1 = {8'd3, 8'd4, 3'd2, 3'd2, 3'd2};
    v0 = 1'b1;
    v1 = 1'b1;
    for (int i = 0; i < 6; i++) tick("alternate", (i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0, 0);
    v1 = 1'b0;

    p0 = {8'd15, 8'd23, 3'd5, 3'd6, 3'd4};
    tick("edge_in", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    p0 = {8'd16, 8'd0, 3'd1, 3'd2, 3'd3};
    tick("x_oob", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    v0 = 1'b0;
    p1 = {8'd0, 8'd24, 3'd1, 3'd2, 3'd3};
    v1 = 1'b1;
    tick("y_oob", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    v1 = 1'b0;

    // Clear wins over a pending req0, which is served right after the sweep.
    p0 = {8'd9, 8'd9, 3'd1, 3'd2, 3'd3};
    v0 = 1'b1;
    clear_start = 1'b1;
    tick("clr_start", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_sweep("sweep1", NPIX);
    tick("post_sweep1", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // req0 was granted last; a clear between must not disturb that, so req1 wins next.
    p0 = {8'd5, 8'd6, 3'd7, 3'd7, 3'd7};
    p1 = {8'd7, 8'd8, 3'd6, 3'd5, 3'd4};
    v1 = 1'b1;
    clear_start = 1'b1;
    tick("clr_both", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_sweep("sweep2", 3);
    tick("post_sweep2", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    v1 = 1'b0;
    tick("post_sweep2b", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    v0 = 1'b0;

    clear_start = 1'b1;
    tick("clr_abort", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    clear_start = 1'b0;
    for (int unsigned k = 0; k < 4; k++) tick("sweep_abort", 1'b0, 1'b0, 1'b1, 1'b1, k);
    do_reset("reset_mid_clear");
    clear_start = 1'b1;
    tick("clr_again", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    clear_start = 1'b0;
    for (int unsigned k = 0; k < 3; k++) tick("sweep_again", 1'b0, 1'b0, 1'b1, 1'b1, k);

    do_reset("reset3");
    p1 = {8'd200, 8'd0, 3'd1, 3'd1, 3'd1};
    v1 = 1'b1;
    tick("oob_one", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (70000) @(posedge clock);
    #1;
    chk("oob_saturate", 32'(oob_count), 32'hFFFF);
    chk("oob_no_write", 32'(out_we), 32'd0);
    v1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
